// File: rtl/micro_sequencer.sv
// Micro-instruction sequencer: owns the micro-PC, fetches micro-words over a
// req/valid handshake and steps FETCH -> DECODE -> EXECUTE1 -> EXECUTE2.
module micro_sequencer #(
  parameter int unsigned UPC_WIDTH    = 10,
  parameter int unsigned UINSTR_WIDTH = 44,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_reset,
  input  logic                    run,
  output logic                    umem_req,
  output logic [UPC_WIDTH-1:0]    umem_addr,
  input  logic                    umem_valid,
  input  logic [UINSTR_WIDTH-1:0] umem_rdata,
  output logic [UINSTR_WIDTH-1:0] uinstr,
  output logic [1:0]              cpu_state,
  input  logic                    is_branch,
  input  logic [9:0]              branch_target,
  input  logic                    branch_cond,
  output logic [UPC_WIDTH-1:0]    upc,
  output logic                    halted,
  output logic [CNT_WIDTH-1:0]    instr_count
);

  localparam int unsigned STATE_W = 2;
  localparam int unsigned OP_W    = 3;

  localparam logic [STATE_W-1:0] FETCH    = 2'd0;
  localparam logic [STATE_W-1:0] DECODE   = 2'd1;
  localparam logic [STATE_W-1:0] EXECUTE1 = 2'd2;
  localparam logic [STATE_W-1:0] EXECUTE2 = 2'd3;

  localparam logic [OP_W-1:0]    OP_HALT  = 3'b111;

  logic [STATE_W-1:0]      state_q, state_d;
  logic                    umem_req_q, umem_req_d;
  logic [UPC_WIDTH-1:0]    upc_q, upc_d;
  logic [UINSTR_WIDTH-1:0] uinstr_q, uinstr_d;
  logic                    halted_q, halted_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic fetch_accept_c;
  logic is_halt_c;
  logic take_branch_c;

  assign fetch_accept_c = (state_q == FETCH) && umem_req_q && umem_valid;
  assign is_halt_c      = (uinstr_q[UINSTR_WIDTH-1 -: OP_W] == OP_HALT);
  assign take_branch_c  = is_branch && branch_cond;

  // State and datapath registers; reset wins over every other event.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q    <= FETCH;
      umem_req_q <= 1'b0;
      upc_q      <= '0;
      uinstr_q   <= '0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      umem_req_q <= umem_req_d;
      upc_q      <= upc_d;
      uinstr_q   <= uinstr_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (fetch_accept_c) state_d = DECODE;
      DECODE:   state_d = is_halt_c ? FETCH : EXECUTE1;
      EXECUTE1: state_d = EXECUTE2;
      EXECUTE2: state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // Datapath updates; a HALT word leaves upc and the counter untouched.
  always_comb begin
    umem_req_d = umem_req_q;
    upc_d      = upc_q;
    uinstr_d   = uinstr_q;
    halted_d   = halted_q;
    cnt_d      = cnt_q;
    case (state_q)
      FETCH: begin
        if (!umem_req_q && run && !halted_q) begin
          umem_req_d = 1'b1;
        end else if (fetch_accept_c) begin
          umem_req_d = 1'b0;
          uinstr_d   = umem_rdata;
        end
      end
      DECODE: begin
        if (is_halt_c) halted_d = 1'b1;
      end
      EXECUTE2: begin
        upc_d = take_branch_c ? UPC_WIDTH'(branch_target) : upc_q + UPC_WIDTH'(1);
        if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      default: ;
    endcase
  end

  assign umem_req    = umem_req_q;
  assign umem_addr   = upc_q;
  assign uinstr      = uinstr_q;
  assign cpu_state   = state_q;
  assign upc         = upc_q;
  assign halted      = halted_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: a micro-memory model answers fetches,
// a monitor checks every fetch/decode against expectations queued by the stimulus.
module tb_micro_sequencer;

  localparam int unsigned UW = 10;
  localparam int unsigned IW = 44;
  localparam int unsigned CW = 16;

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;

  logic          sys_clk;
  logic          sys_reset;
  logic          run;
  logic          umem_req;
  logic [UW-1:0] umem_addr;
  logic          umem_valid;
  logic [IW-1:0] umem_rdata;
  logic [IW-1:0] uinstr;
  logic [1:0]    cpu_state;
  logic          is_branch;
  logic [9:0]    branch_target;
  logic          branch_cond;
  logic [UW-1:0] upc;
  logic          halted;
  logic [CW-1:0] instr_count;

  micro_sequencer #(.UPC_WIDTH(UW), .UINSTR_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .sys_clk       (sys_clk),
    .sys_reset     (sys_reset),
    .run           (run),
    .umem_req      (umem_req),
    .umem_addr     (umem_addr),
    .umem_valid    (umem_valid),
    .umem_rdata    (umem_rdata),
    .uinstr        (uinstr),
    .cpu_state     (cpu_state),
    .is_branch     (is_branch),
    .branch_target (branch_target),
    .branch_cond   (branch_cond),
    .upc           (upc),
    .halted        (halted),
    .instr_count   (instr_count)
  );

  typedef struct {
    logic [UW-1:0] addr;
    logic [IW-1:0] word;
    int            len;
    int            gap;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur;
  logic [IW-1:0] mem [0:1023];
  logic [IW-1:0] last_word;
  logic [IW-1:0] halt_w;
  int            n_cmp = 0;
  int            n_err = 0;
  int            delay = 0;
  bit            spur  = 1'b0;
  int            wait_cnt = 0;
  int            cyc = 0;
  int            last_rise = 0;
  int            req_len = 0;
  logic          req_prev = 1'b0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic br, input logic cnd,
                                       input logic [9:0] tgt, input int seed);
    return {op, br, cnd, 29'(seed * 13 + 5), tgt};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [UW-1:0] a, input logic [IW-1:0] w, input int len, input int gap);
    exp_t e;
    e.addr = a; e.word = w; e.len = len; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Micro-memory: answers after `delay` wait cycles; optional noise while idle.
  always @(negedge sys_clk) begin
    if (umem_req) begin
      if (wait_cnt >= delay) begin
        umem_valid = 1'b1;
        umem_rdata = mem[umem_addr];
      end else begin
        umem_valid = 1'b0;
        wait_cnt++;
      end
    end else begin
      wait_cnt   = 0;
      umem_valid = spur && ($urandom_range(0, 1) == 1);
      umem_rdata = IW'({$urandom(), $urandom()});
    end
  end

  // Decode register model: captures branch fields from the word held in DECODE.
  always @(negedge sys_clk) begin
    if (sys_reset) begin
      is_branch = 1'b0; branch_cond = 1'b0; branch_target = '0;
    end else if (cpu_state == S_DECODE) begin
      is_branch     = uinstr[40];
      branch_cond   = uinstr[39];
      branch_target = uinstr[9:0];
    end
  end

  // Monitor: pops an expectation on each new request and checks it through decode.
  always @(negedge sys_clk) begin
    cyc++;
    if (sys_reset) last_word = '0;
    if (umem_req && !req_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_fetch: got addr %0h expected none", umem_addr);
      end else begin
        cur = exp_q.pop_front();
        chk("fetch_addr", 64'(umem_addr), 64'(cur.addr));
        if (cur.gap != 0) chk("fetch_period", 64'(cyc - last_rise), 64'(cur.gap));
        chk("uinstr_hold", 64'(uinstr), 64'(last_word));
      end
      last_rise = cyc;
      req_len   = 0;
    end
    if (umem_req) req_len++;
    if (!umem_req && req_prev) chk("req_length", 64'(req_len), 64'(cur.len));
    if (cpu_state == S_DECODE) begin
      chk("decode_word", 64'(uinstr), 64'(cur.word));
      last_word = cur.word;
    end
    req_prev = umem_req;
  end

  task automatic fill_halt();
    for (int i = 0; i < 1024; i++) mem[i] = halt_w;
  endtask

  task automatic reset_dut();
    run = 1'b0;
    sys_reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, 64'(cpu_state), 64'(S_FETCH));
    chk({tag, "_upc"},   64'(upc), 64'd0);
    chk({tag, "_req"},   64'(umem_req), 64'd0);
    chk({tag, "_addr"},  64'(umem_addr), 64'd0);
    chk({tag, "_uinstr"}, 64'(uinstr), 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
    chk({tag, "_count"}, 64'(instr_count), 64'd0);
  endtask

  task automatic wait_halt(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge sys_clk);
      if (halted) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("halt_timeout", 64'd0, 64'd1);
  endtask

  task automatic finish_phase(input string tag, input logic [UW-1:0] exp_upc, input int exp_cnt);
    int req_seen;
    chk({tag, "_halted"}, 64'(halted), 64'd1);
    chk({tag, "_state"},  64'(cpu_state), 64'(S_FETCH));
    chk({tag, "_upc"},    64'(upc), 64'(exp_upc));
    chk({tag, "_count"},  64'(instr_count), 64'(exp_cnt));
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (umem_req || cpu_state != S_FETCH) req_seen++;
    end
    chk({tag, "_idle_when_halted"}, 64'(req_seen), 64'd0);
    chk({tag, "_count_held"}, 64'(instr_count), 64'(exp_cnt));
    chk({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [IW-1:0] w;
    halt_w = mk(3'b111, 1'b0, 1'b0, 10'd0, 0);
    sys_reset = 1'b1; run = 1'b0;
    is_branch = 1'b0; branch_cond = 1'b0; branch_target = '0;
    umem_valid = 1'b0; umem_rdata = '0;
    last_word = '0;
    fill_halt();

    // Straight-line code 0..6, HALT at 7, single-cycle memory.
    reset_dut();
    check_reset_vals("reset");
    for (int a = 0; a < 7; a++) begin
      mem[a] = mk(3'b001, 1'b0, 1'b0, 10'(a * 3), a);
      push(UW'(a), mem[a], 1, (a == 0) ? 0 : 5);
    end
    push(UW'(7), halt_w, 1, 5);
    run = 1'b1;
    wait_halt(200);
    finish_phase("linear", UW'(7), 7);

    // Taken branch 5 -> 0x3A0.
    reset_dut(); fill_halt();
    mem[0]     = mk(3'b010, 1'b1, 1'b1, 10'h005, 1);
    mem[5]     = mk(3'b010, 1'b1, 1'b1, 10'h3A0, 2);
    push(UW'(0), mem[0], 1, 0);
    push(UW'(5), mem[5], 1, 5);
    push(UW'(10'h3A0), halt_w, 1, 5);
    run = 1'b1;
    wait_halt(200);
    finish_phase("br_taken", UW'(10'h3A0), 2);

    // Same branch with condition false falls through to 6.
    reset_dut(); fill_halt();
    mem[0] = mk(3'b010, 1'b1, 1'b1, 10'h005, 3);
    mem[5] = mk(3'b010, 1'b1, 1'b0, 10'h3A0, 4);
    push(UW'(0), mem[0], 1, 0);
    push(UW'(5), mem[5], 1, 5);
    push(UW'(6), halt_w, 1, 5);
    run = 1'b1;
    wait_halt(200);
    finish_phase("br_not_taken", UW'(6), 2);

    // 3-cycle memory latency, idle noise on umem_valid, upc wrap 1023 -> 0.
    reset_dut(); fill_halt();
    delay = 3; spur = 1'b1;
    mem[0]       = mk(3'b010, 1'b1, 1'b1, 10'h3FE, 5);
    mem[10'h3FE] = mk(3'b001, 1'b0, 1'b0, 10'h155, 6);
    mem[10'h3FF] = mk(3'b001, 1'b0, 1'b1, 10'h2AA, 7);
    push(UW'(0), mem[0], 4, 0);
    push(UW'(10'h3FE), mem[10'h3FE], 4, 8);
    push(UW'(10'h3FF), mem[10'h3FF], 4, 8);
    push(UW'(0), halt_w, 4, 8);
    run = 1'b1;
    for (int i = 0; i < 100 && upc != UW'(10'h3FE); i++) @(negedge sys_clk);
    chk("reach_3fe", 64'(upc), 64'h3FE);
    mem[0] = halt_w;
    wait_halt(300);
    finish_phase("wrap", UW'(0), 3);
    spur = 1'b0;

    // Reset while a slow fetch is outstanding; late response must be ignored.
    reset_dut(); fill_halt();
    delay = 5;
    mem[0] = mk(3'b001, 1'b0, 1'b0, 10'h0AB, 8);
    push(UW'(0), mem[0], 2, 0);
    run = 1'b1;
    for (int i = 0; i < 20 && !umem_req; i++) @(negedge sys_clk);
    @(negedge sys_clk);
    #1 sys_reset = 1'b1;
    run = 1'b0;
    @(negedge sys_clk);
    check_reset_vals("mid_fetch_reset");
    sys_reset = 1'b0;
    spur = 1'b1;
    repeat (6) @(negedge sys_clk);
    chk("late_valid_uinstr", 64'(uinstr), 64'd0);
    chk("late_valid_state", 64'(cpu_state), 64'(S_FETCH));
    chk("late_valid_req", 64'(umem_req), 64'd0);
    spur = 1'b0; delay = 0;
    mem[0] = halt_w;
    push(UW'(0), halt_w, 1, 0);
    run = 1'b1;
    wait_halt(200);
    finish_phase("restart", UW'(0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Micro-instruction sequencer for the micro-coded CPU. It owns the micro-PC and drives the `cpu_state` bus (FETCH, DECODE, EXECUTE1, EXECUTE2) that the decode register and micro register file consume. It fetches 44-bit micro-instructions from micro-memory over a req/valid handshake and holds each word stable for the decoder. It resolves branches from the registered decode fields and detects HALT.

## Interface
Parameters:
- `UPC_WIDTH`, 10: micro-PC width; matches the 10-bit branch_target field.
- `UINSTR_WIDTH`, 44: micro-instruction width.
- `CNT_WIDTH`, 16: width of the retired-instruction counter.

Ports (one clock; reset is synchronous and active-high):
- `sys_clk`  in  1: system clock; all state updates on the rising edge.
- `sys_reset`  in  1: synchronous, active-high reset.
- `run`  in  1: level; permits starting a new fetch.
- `umem_req`  out  1: fetch request, registered.
- `umem_addr`  out  UPC_WIDTH: fetch address; equals `upc` while `umem_req`=1.
- `umem_valid`  in  1: micro-memory response valid.
- `umem_rdata`  in  UINSTR_WIDTH: micro-instruction returned with `umem_valid`.
- `uinstr`  out  UINSTR_WIDTH: held micro-instruction; feeds the decoder.
- `cpu_state`  out  $clog2(`CPU_STATES): current state, using the `FETCH`/`DECODE`/`EXECUTE1`/`EXECUTE2` encodings from defines.vh.
- `is_branch`  in  1: registered branch flag from the decode register.
- `branch_target`  in  10: registered branch target from the decode register.
- `branch_cond`  in  1: branch-taken condition from the ALU; sampled in EXECUTE2.
- `upc`  out  UPC_WIDTH: current micro-PC.
- `halted`  out  1: sticky; set by a HALT micro-instruction.
- `instr_count`  out  CNT_WIDTH: count of retired micro-instructions.

## Operation
- Reset values: `cpu_state`=`FETCH`, `upc`=0, `umem_req`=0, `umem_addr`=0, `uinstr`=0, `halted`=0, `instr_count`=0.
- **FETCH**
  - When `umem_req`=0, `run`=1 and `halted`=0: next cycle `umem_req`=1 and `umem_addr`=`upc`.
  - `umem_req` stays high until an edge where `umem_req`=1 and `umem_valid`=1.
  - On that edge: `uinstr`<=`umem_rdata`, `umem_req`<=0, state<=`DECODE`.
  - `umem_valid` while `umem_req`=0 is ignored.
  - `run` falling after a request is issued does not abort it. `run` gates only the start of a new fetch.
- **DECODE** (exactly 1 cycle)
  - `uinstr` is held; the decode register captures the decoder outputs at the end of this cycle.
  - If `uinstr[43:41]`==3'b111 (HALT): `halted`<=1, state<=`FETCH`, `upc` unchanged, no execute states, `instr_count` unchanged.
  - Otherwise state<=`EXECUTE1`.
- **EXECUTE1** (1 cycle): state<=`EXECUTE2`.
- **EXECUTE2** (1 cycle)
  - `upc`<=`branch_target` if `is_branch`=1 and `branch_cond`=1; otherwise `upc`<=`upc`+1, modulo 2^UPC_WIDTH (1023 wraps to 0).
  - `instr_count`<=`instr_count`+1, saturating at all-ones.
  - state<=`FETCH`.
- **Halted**
  - State remains `FETCH` and `umem_req` stays 0 regardless of `run`.
  - Only `sys_reset` clears `halted`.
- `uinstr` changes only on fetch acceptance; it holds through DECODE/EXECUTE1/EXECUTE2 and the next FETCH wait.
- `is_branch` is ignored outside EXECUTE2.

## Timing
- Minimum micro-instruction period is 5 cycles: request-issue edge, accept edge (`umem_valid` in the first `umem_req` cycle), DECODE, EXECUTE1, EXECUTE2.
- Each memory wait cycle adds 1.
- `cpu_state` is registered; it changes only on the clock edges listed above.
- Reset mid-fetch: `umem_req`=0 on the cycle after the reset edge. A late `umem_valid` is ignored.
- Reset mid-execute: `upc` and `instr_count` return to 0 with no retirement.
- Reset has priority over all other events on the same edge.
- A branch to `upc` itself (self-loop) is legal and re-fetches the same address.

## Test plan
- Reset, `run`=1, memory returns `umem_valid` in the first `umem_req` cycle with words at addresses 0,1,2 (non-branch) -> `umem_addr` sequence 0,1,2; states cycle FETCH→DECODE→E1→E2 with 5-cycle period; `instr_count`=3.
- Word at addr 5 has `is_branch`=1, `branch_target`=0x3A0, `branch_cond`=1 -> next `umem_addr`=0x3A0. Repeat with `branch_cond`=0 -> next `umem_addr`=6.
- Memory delays `umem_valid` by 3 cycles and pulses spurious `umem_valid` while `umem_req`=0 -> `umem_req` held for 4 cycles; `uinstr` captured only on the accepted edge; spurious pulses change nothing.
- `upc`=1023, non-branch instruction -> next `umem_addr`=0.
- HALT word (bits 43:41=111) at addr 7 -> `halted`=1, `upc`=7, `cpu_state`=FETCH, `umem_req` stays 0 for 20 cycles with `run`=1; `instr_count` unchanged.
- Assert `sys_reset` while `umem_req`=1, then return `umem_valid` after reset -> all outputs at reset values; late response ignored; restart fetches address 0.
